button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
Conditions the four raw DE-board push-buttons before they reach the button PIO of the count_binary system.
- Synchronizes each active-low key to the system clock and filters contact bounce with a per-button stability counter.
- Presents a clean active-high "pressed" level to the PIO input.
- Also produces one-cycle press/release strobes for local logic, e.g. an edge-capture interrupt source.

Parameters:
- NUM_BUTTONS, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, consecutive clock cycles a synchronized input must hold a new value before it is accepted (10 ms at 50 MHz). Legal range >= 1.
- KEY_ACTIVE_LOW, 1. 1 = raw key reads 0 when pressed; 0 = raw key reads 1 when pressed.

Ports:
- clk_clk  input  1  system clock; same net as sys_sdram_pll_0_ref_clk_clk.
- reset_reset  input  1  synchronous, active-high reset.
- key_raw  input  NUM_BUTTONS  asynchronous raw button pins.
- button_pio_external_connection_export  output  NUM_BUTTONS  debounced level, 1 = pressed; drives the button PIO input.
- press_pulse  output  NUM_BUTTONS  one-cycle strobe on an accepted press.
- release_pulse  output  NUM_BUTTONS  one-cycle strobe on an accepted release.

Behaviour:
- One clock (clk_clk). Reset is synchronous and active-high (reset_reset). All state updates on the rising edge only.
- Per channel, a 2-flop synchronizer samples key_raw. Polarity is normalized after the second flop: pressed = sync2 XOR KEY_ACTIVE_LOW.
- Reset values:
  - synchronizer flops = released raw value (1 if KEY_ACTIVE_LOW, else 0)
  - stable level = 0
  - counter = 0
  - press_pulse = 0, release_pulse = 0, button_pio_external_connection_export = 0
- Counter width is $clog2(DEBOUNCE_CYCLES+1). Unsigned; never wraps, because it clears before it can overflow.
- Per-channel FSM, 2 states:
  - STABLE: normalized input == stable level. Counter held at 0, no pulses.
  - CHANGING: normalized input != stable level. Counter increments by 1 each cycle.
  - CHANGING -> STABLE with accept: when the counter == DEBOUNCE_CYCLES-1 and the input still differs on that cycle. Stable level toggles, counter clears, and exactly one pulse fires in the same cycle the level changes (press_pulse if new level 1, release_pulse if 0).
  - CHANGING -> STABLE without accept: if the input returns to the stable level before acceptance (a bounce), counter clears to 0. No level change, no pulse.
- Latency: a clean step on key_raw appears on the output 2 + DEBOUNCE_CYCLES rising edges later. Pulses are coincident with the level change.
- DEBOUNCE_CYCLES = 1: a change is accepted on the first cycle it is seen after synchronization (total latency 3 edges).
- Channels are fully independent. Simultaneous presses on several buttons produce simultaneous pulses.
- press_pulse and release_pulse are never both high on the same channel.
- Reset mid-count: everything returns to reset values on the next edge and no pulse is emitted. A button held through reset is re-accepted as a press 2 + DEBOUNCE_CYCLES edges after reset deasserts.
- Outputs are registered; there is no combinational path from key_raw to any output.

Decomposition:
- Shared package count_binary_pkg:
  - default NUM_BUTTONS
  - CLK_FREQ_HZ = 50_000_000
  - DEBOUNCE_MS = 10
  - localparam function computing DEBOUNCE_CYCLES from CLK_FREQ_HZ and DEBOUNCE_MS
- Sub-module debounce_channel: synchronizer, counter, 2-state FSM and pulse logic for one bit. The top instantiates it NUM_BUTTONS times in a generate loop.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, KEY_ACTIVE_LOW=1.
1. Reset with key_raw=4'b1111 held 20 cycles -> export=0000 and both pulse buses 0 throughout.
2. key_raw[0] 1->0 clean step -> export[0]=1 and press_pulse[0]=1 for exactly one cycle, 10 edges after the step. Other bits stay 0.
3. key_raw[1] toggles low/high every 3 cycles for 30 cycles, then held low -> no pulse during bouncing. Press accepted 10 edges after the final falling edge.
4. Buttons 2 and 3 pressed on the same cycle, released 50 cycles later -> simultaneous press_pulse=4'b1100. Simultaneous release_pulse=4'b1100 10 edges after release. Export returns to 0000.
5. Button 0 held low, reset_reset asserted 1 cycle at count 5 -> export=0, no pulse on the reset cycle. Press re-accepted 10 edges after reset deasserts.
6. Press and release a 7-cycle low glitch (one less than DEBOUNCE_CYCLES) -> no change, no pulse. An 8-cycle glitch -> press accepted, followed by release accepted.

Source files
------------

// File: rtl/count_binary_pkg.sv
// count_binary_pkg: shared constants, types and helpers for the count_binary button path.
// No ports. Provides the default button count, the system clock rate, the debounce
// window in milliseconds, the derived debounce cycle count and the per-channel FSM state type.
package count_binary_pkg;

    localparam int NUM_BUTTONS_DEFAULT = 4;
    localparam int CLK_FREQ_HZ         = 50_000_000;
    localparam int DEBOUNCE_MS         = 10;

    function automatic int debounce_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    localparam int DEBOUNCE_CYCLES_DEFAULT = debounce_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);

    typedef enum logic {
        STABLE,
        CHANGING
    } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronizes and debounces one raw key, emitting a clean level and edge strobes.
// Ports:
//   clk_clk       system clock, all state on the rising edge
//   reset_reset   synchronous active-high reset
//   key_raw       asynchronous raw key pin
//   level         debounced level, 1 = pressed
//   press_pulse   one-cycle strobe when a press is accepted
//   release_pulse one-cycle strobe when a release is accepted
module debounce_channel
    import count_binary_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic key_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic          pressed, diff;
    logic [CW-1:0] cnt, cnt_cur, cnt_d;
    deb_state_e    state, state_d;
    logic          level_d, press_d, release_d;

    assign pressed = sync2 ^ KEY_ACTIVE_LOW;
    assign diff    = pressed ^ level;
    // The counter is only meaningful while a change is being timed.
    assign cnt_cur = (state == CHANGING) ? cnt : '0;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1         <= KEY_ACTIVE_LOW;
            sync2         <= KEY_ACTIVE_LOW;
            state         <= STABLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= key_raw;
            sync2         <= sync1;
            state         <= state_d;
            cnt           <= cnt_d;
            level         <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // A bounce (diff drops) falls through to the defaults: back to STABLE with a cleared count.
    always_comb begin
        state_d   = STABLE;
        cnt_d     = '0;
        level_d   = level;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (diff && cnt_cur == LAST) begin
            level_d   = ~level;
            press_d   = ~level;
            release_d = level;
        end else if (diff) begin
            state_d = CHANGING;
            cnt_d   = cnt_cur + 1'b1;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: conditions the raw DE-board push-buttons for the count_binary button PIO.
// Ports:
//   clk_clk                                system clock
//   reset_reset                            synchronous active-high reset
//   key_raw                                asynchronous raw key pins
//   button_pio_external_connection_export  debounced levels, 1 = pressed
//   press_pulse                            one-cycle strobes on accepted presses
//   release_pulse                          one-cycle strobes on accepted releases
module button_debounce
    import count_binary_pkg::*;
#(
    parameter int NUM_BUTTONS     = NUM_BUTTONS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [NUM_BUTTONS-1:0] key_raw,
    output logic [NUM_BUTTONS-1:0] button_pio_external_connection_export,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW != 0)
        ) u_ch (
            .clk_clk       (clk_clk),
            .reset_reset   (reset_reset),
            .key_raw       (key_raw[i]),
            .level         (button_pio_external_connection_export[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench for button_debounce with DEBOUNCE_CYCLES=8, active-low keys.
module tb_button_debounce;

    typedef struct {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] pr;
        logic [3:0] rl;
    } ev_t;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic [3:0] key_raw;
    logic [3:0] export_lvl, press_pulse, release_pulse;

    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    bit   mon_on = 1'b0;
    ev_t  sb[$];
    logic [3:0] model_lvl = 4'b0000;
    logic [3:0] exp_lvl   = 4'b0000;

    button_debounce #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (8),
        .KEY_ACTIVE_LOW  (1)
    ) dut (
        .clk_clk                               (clk_clk),
        .reset_reset                           (reset_reset),
        .key_raw                               (key_raw),
        .button_pio_external_connection_export (export_lvl),
        .press_pulse                           (press_pulse),
        .release_pulse                         (release_pulse)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc++;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        else passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Record an expected accepted edge dt edges after the input driven on this negedge.
    task automatic expect_at(input int dt, input logic [3:0] pr, input logic [3:0] rl);
        ev_t e;
        model_lvl = (model_lvl | pr) & ~rl;
        e.cyc = cyc + dt;
        e.lvl = model_lvl;
        e.pr  = pr;
        e.rl  = rl;
        sb.push_back(e);
    endtask

    always @(negedge clk_clk) begin
        logic [3:0] exp_p, exp_r;
        ev_t e;
        if (mon_on) begin
            exp_p = 4'b0000;
            exp_r = 4'b0000;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e       = sb.pop_front();
                exp_lvl = e.lvl;
                exp_p   = e.pr;
                exp_r   = e.rl;
            end
            check("export", export_lvl, exp_lvl);
            check("press", press_pulse, exp_p);
            check("release", release_pulse, exp_r);
        end
    end

    initial begin
        int budget;
        reset_reset = 1'b1;
        key_raw     = 4'b1111;
        @(negedge clk_clk);
        mon_on = 1'b1;
        // reset held with keys released
        tick(20);
        reset_reset = 1'b0;
        tick(5);
        // clean press/release of button 0
        key_raw = 4'b1110; expect_at(10, 4'b0001, 4'b0000);
        tick(20);
        key_raw = 4'b1111; expect_at(10, 4'b0000, 4'b0001);
        tick(20);
        // bouncing button 1, then a held press
        for (int i = 0; i < 5; i++) begin
            key_raw = 4'b1101; tick(3);
            key_raw = 4'b1111; tick(3);
        end
        key_raw = 4'b1101; expect_at(10, 4'b0010, 4'b0000);
        tick(20);
        key_raw = 4'b1111; expect_at(10, 4'b0000, 4'b0010);
        tick(20);
        // buttons 2 and 3 together
        key_raw = 4'b0011; expect_at(10, 4'b1100, 4'b0000);
        tick(50);
        key_raw = 4'b1111; expect_at(10, 4'b0000, 4'b1100);
        tick(20);
        // reset mid-count with button 0 held, then re-accept
        key_raw = 4'b1110;
        tick(7);
        reset_reset = 1'b1;
        tick(1);
        reset_reset = 1'b0; expect_at(10, 4'b0001, 4'b0000);
        tick(20);
        key_raw = 4'b1111; expect_at(10, 4'b0000, 4'b0001);
        tick(20);
        // 7-cycle glitch rejected, 8-cycle glitch accepted
        key_raw = 4'b1110; tick(7);
        key_raw = 4'b1111; tick(20);
        key_raw = 4'b1110; expect_at(10, 4'b0001, 4'b0000);
        tick(8);
        key_raw = 4'b1111; expect_at(10, 4'b0000, 4'b0001);
        budget = 0;
        while (sb.size() > 0 && budget < 200) begin
            tick(1);
            budget++;
        end
        check("drained", 4'(sb.size()), 4'd0);
        tick(10);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
